ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
Two-requester arbiter sharing the single-port 256x16 program/data RAM between the CPU memory path (MAR/MBR) and a program loader/debug port. It serialises accesses with a req/ack handshake, drives the RAM port, and returns registered read data and an error flag for out-of-range addresses.

Parameters:
ADDR_W, 8, address width for both requesters and RAM
DATA_W, 16, data width
RAM_LAT, 1, cycles from the RAM sampling ram_en to ram_rdata being valid; range 1..4
MEM_DEPTH, 256, number of implemented words; addresses >= MEM_DEPTH are errors
LD_PRIORITY, 0, 0 = round-robin; 1 = loader always wins ties

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
cpu_req  in  1  CPU request; held high with stable we/addr/wdata until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  read data, valid while cpu_ack is high
cpu_err  out  1  high with cpu_ack if the address was out of range
ld_req, ld_we, ld_addr, ld_wdata  in  1/1/ADDR_W/DATA_W  loader request group, same rules as cpu_*
ld_ack, ld_rdata, ld_err  out  1/DATA_W/1  loader response group, same rules as cpu_*
ram_en  out  1  RAM access strobe, exactly one cycle per access
ram_we  out  1  RAM write enable, qualified by ram_en
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data
grant  out  2  one-hot owner; bit0 = CPU, bit1 = loader; 00 when idle
busy  out  1  high in every state except IDLE

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, ACK. All outputs are registered.
- Reset (synchronous, rst=1 at a clock edge):
  - state returns to IDLE and any in-flight transaction is dropped with no ack; requesters must reissue.
  - Cleared: all acks, errs, ram_en, ram_we, grant, busy, and both rdata registers (to 0).
  - last_grant is set to loader, so the CPU wins the first tie.
- IDLE: if any req is high, select the winner.
  - One req high: that requester wins.
  - Both high, LD_PRIORITY=0: the requester that is not last_grant wins.
  - Both high, LD_PRIORITY=1: the loader wins.
  - Latch the winner's we/addr/wdata, set grant, update last_grant.
  - Address < MEM_DEPTH: go to ISSUE. Otherwise go directly to ACK with err=1 and do not access the RAM.
- ISSUE (1 cycle): ram_en=1; ram_we/ram_addr/ram_wdata come from the latched values. Then go to WAIT.
- WAIT (RAM_LAT cycles, via a down-counter):
  - On the last WAIT cycle's edge, capture ram_rdata into the winner's rdata register (reads only).
  - Then go to ACK.
- ACK (1 cycle):
  - Winner's ack=1; err as determined in IDLE.
  - rdata is valid for reads; for writes and errors the rdata register holds its previous value.
  - Then go to IDLE with grant=00.
- Latency: req high in IDLE cycle t gives ack in cycle t+2+RAM_LAT. An error gives ack in cycle t+1.
- Handshake rules:
  - Requester deasserts req (or issues a new request) after seeing ack.
  - The arbiter never samples req in the ACK cycle. The loser's req stays pending and is granted at the next IDLE.
- The non-granted requester's ack, err and rdata are unaffected by the other requester's transaction.
- Starvation freedom: in round-robin mode each requester waits for at most one foreign transaction.
- Request fields that change while the request is granted are ignored, because the latched copy is used.

Test Plan:
- Reset, then CPU write addr 0x10 data 0x1234, then CPU read 0x10 (RAM_LAT=1) -> ram_en pulses once per access; read ack arrives 3 cycles after req with cpu_rdata=0x1234; grant=01 throughout each access.
- cpu_req and ld_req rise in the same cycle, LD_PRIORITY=0, repeated 4 times -> grants alternate CPU, LD, CPU, LD; each ack is exactly one cycle wide.
- Same stimulus with LD_PRIORITY=1 and ld_req held continuously -> loader is granted every transaction; CPU is granted only in an IDLE where ld_req=0.
- Loader read at addr 0xFF with MEM_DEPTH=128 -> ld_ack and ld_err high 1 cycle after req; ram_en never asserts; ld_rdata unchanged.
- rst asserted during WAIT of a CPU read -> next cycle IDLE, busy=0, no cpu_ack; the reissued read completes normally.
- RAM_LAT=3, loader writes 0xBEEF to 0x05, CPU reads 0x05 -> ld_ack 5 cycles after req; cpu_rdata=0xBEEF.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-requester arbiter (CPU path and loader/debug port) for a single-port RAM.
// Accesses are serialised via req/ack handshakes; all outputs are registered.
module ram_arbiter #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned RAM_LAT     = 1,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned LD_PRIORITY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        grant,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t            state, state_nxt;
  logic              any_req, pick_ld, addr_ok, sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              last_ld, owner_ld, lat_we;
  logic [2:0]        cnt;

  // Winner selection; last_ld only matters for round-robin ties.
  always_comb begin
    any_req = cpu_req | ld_req;
    pick_ld = 1'b0;
    if (ld_req && !cpu_req)
      pick_ld = 1'b1;
    else if (ld_req && cpu_req)
      pick_ld = (LD_PRIORITY != 0) || !last_ld;
    sel_we    = pick_ld ? ld_we    : cpu_we;
    sel_addr  = pick_ld ? ld_addr  : cpu_addr;
    sel_wdata = pick_ld ? ld_wdata : cpu_wdata;
  end

  assign addr_ok = (33'(sel_addr) < 33'(MEM_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = addr_ok ? ISSUE : ACK;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt == 3'd0) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ram_addr/ram_wdata double as the latched request copy for the whole access.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_ld   <= 1'b1;
      owner_ld  <= 1'b0;
      lat_we    <= 1'b0;
      cnt       <= 3'd0;
      cpu_ack   <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
      ld_ack    <= 1'b0;
      ld_err    <= 1'b0;
      ld_rdata  <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      grant     <= 2'b00;
      busy      <= 1'b0;
    end else begin
      ram_en  <= 1'b0;
      ram_we  <= 1'b0;
      cpu_ack <= 1'b0;
      cpu_err <= 1'b0;
      ld_ack  <= 1'b0;
      ld_err  <= 1'b0;
      busy    <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          if (any_req) begin
            owner_ld  <= pick_ld;
            last_ld   <= pick_ld;
            lat_we    <= sel_we;
            ram_addr  <= sel_addr;
            ram_wdata <= sel_wdata;
            grant     <= pick_ld ? 2'b10 : 2'b01;
            if (addr_ok) begin
              ram_en <= 1'b1;
              ram_we <= sel_we;
            end else begin
              cpu_ack <= !pick_ld;
              cpu_err <= !pick_ld;
              ld_ack  <= pick_ld;
              ld_err  <= pick_ld;
            end
          end
        end
        ISSUE: cnt <= 3'(RAM_LAT - 1);
        WAIT: begin
          if (cnt == 3'd0) begin
            cpu_ack <= !owner_ld;
            ld_ack  <= owner_ld;
            if (!lat_we) begin
              if (owner_ld) ld_rdata  <= ram_rdata;
              else          cpu_rdata <= ram_rdata;
            end
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        ACK:     grant <= 2'b00;
        default: grant <= 2'b00;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: two instances (RAM_LAT=1/MEM_DEPTH=128/round-robin and
// RAM_LAT=3/MEM_DEPTH=256/loader-priority), a transaction-level model and directed tests.
module tb_ram_arbiter;

  logic        clk, rst;
  logic        cpu_req [2], cpu_we [2], ld_req [2], ld_we [2];
  logic [7:0]  cpu_addr [2], ld_addr [2], ram_addr [2];
  logic [15:0] cpu_wdata [2], ld_wdata [2], ram_wdata [2], ram_rdata [2];
  logic [15:0] cpu_rdata [2], ld_rdata [2];
  logic        cpu_ack [2], cpu_err [2], ld_ack [2], ld_err [2];
  logic        ram_en [2], ram_we [2], busy [2];
  logic [1:0]  grant [2];

  int n_chk = 0;
  int n_fail = 0;
  int en_cnt [2];

  ram_arbiter #(.ADDR_W(8), .DATA_W(16), .RAM_LAT(1), .MEM_DEPTH(128), .LD_PRIORITY(0)) u0 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
    .cpu_ack(cpu_ack[0]), .cpu_rdata(cpu_rdata[0]), .cpu_err(cpu_err[0]),
    .ld_req(ld_req[0]), .ld_we(ld_we[0]), .ld_addr(ld_addr[0]), .ld_wdata(ld_wdata[0]),
    .ld_ack(ld_ack[0]), .ld_rdata(ld_rdata[0]), .ld_err(ld_err[0]),
    .ram_en(ram_en[0]), .ram_we(ram_we[0]), .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]),
    .ram_rdata(ram_rdata[0]), .grant(grant[0]), .busy(busy[0]));

  ram_arbiter #(.ADDR_W(8), .DATA_W(16), .RAM_LAT(3), .MEM_DEPTH(256), .LD_PRIORITY(1)) u1 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
    .cpu_ack(cpu_ack[1]), .cpu_rdata(cpu_rdata[1]), .cpu_err(cpu_err[1]),
    .ld_req(ld_req[1]), .ld_we(ld_we[1]), .ld_addr(ld_addr[1]), .ld_wdata(ld_wdata[1]),
    .ld_ack(ld_ack[1]), .ld_rdata(ld_rdata[1]), .ld_err(ld_err[1]),
    .ram_en(ram_en[1]), .ram_we(ram_we[1]), .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]),
    .ram_rdata(ram_rdata[1]), .grant(grant[1]), .busy(busy[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction
  function automatic int depth_of(input int i);
    return (i == 0) ? 128 : 256;
  endfunction
  function automatic bit prio_of(input int i);
    return (i == 0) ? 1'b0 : 1'b1;
  endfunction
  function automatic logic [15:0] pat(input logic [7:0] a);
    return {a, a} ^ 16'h5A5A;
  endfunction

  // RAM: contents stored XOR pat(addr), so unwritten words read back as pat(addr).
  bit [15:0] ram_mem [2][256];
  bit [15:0] rpipe [2][4];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ram_en[i] === 1'b1) begin
        if (ram_we[i]) ram_mem[i][ram_addr[i]] <= ram_wdata[i] ^ pat(ram_addr[i]);
        rpipe[i][0] <= ram_mem[i][ram_addr[i]] ^ pat(ram_addr[i]);
      end
      for (int k = 1; k < 4; k++) rpipe[i][k] <= rpipe[i][k-1];
    end
  end
  assign ram_rdata[0] = rpipe[0][0];
  assign ram_rdata[1] = rpipe[1][2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Model: each accepted request is a timestamped transaction; outputs follow from timestamps.
  logic [15:0] m_mem [2][256];
  bit          act [2], own [2], m_we [2], m_err [2], last_ld [2];
  int          st [2], ack_c [2];
  logic [7:0]  m_addr [2];
  logic [15:0] m_wd [2], rd_val [2];
  logic [7:0]  e_ctl [2];
  logic [15:0] e_rd_c [2], e_rd_l [2];
  bit          primed = 1'b0;
  int          cyc = 0;

  task automatic model_step();
    int c, n;
    bit on, ak;
    c = cyc; cyc++; n = c + 1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        act[i] = 0; last_ld[i] = 1; e_rd_c[i] = '0; e_rd_l[i] = '0;
      end else if (!act[i] || c > ack_c[i]) begin
        act[i] = 0;
        if (cpu_req[i] || ld_req[i]) begin
          own[i]     = ld_req[i] && (!cpu_req[i] || prio_of(i) || !last_ld[i]);
          last_ld[i] = own[i];
          m_we[i]    = own[i] ? ld_we[i]    : cpu_we[i];
          m_addr[i]  = own[i] ? ld_addr[i]  : cpu_addr[i];
          m_wd[i]    = own[i] ? ld_wdata[i] : cpu_wdata[i];
          m_err[i]   = int'(m_addr[i]) >= depth_of(i);
          st[i]      = c;
          ack_c[i]   = c + (m_err[i] ? 1 : 2 + lat_of(i));
          act[i]     = 1;
          if (!m_err[i]) begin
            if (m_we[i]) m_mem[i][m_addr[i]] = m_wd[i];
            else         rd_val[i] = m_mem[i][m_addr[i]];
          end
        end
      end
      on = act[i] && n > st[i] && n <= ack_c[i];
      ak = act[i] && n == ack_c[i];
      e_ctl[i] = {ak && !own[i], ak && !own[i] && m_err[i], ak && own[i], ak && own[i] && m_err[i],
                  on ? (own[i] ? 2'b10 : 2'b01) : 2'b00, on, act[i] && !m_err[i] && n == st[i] + 1};
      if (ak && !m_we[i] && !m_err[i]) begin
        if (own[i]) e_rd_l[i] = rd_val[i];
        else        e_rd_c[i] = rd_val[i];
      end
    end
    if (rst) primed = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 256; a++) m_mem[i][a] = pat(8'(a));
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (primed) begin
        for (int i = 0; i < 2; i++) begin
          check($sformatf("u%0d.ctl{ack,err,ldack,lderr,grant,busy,en}", i),
                32'({cpu_ack[i], cpu_err[i], ld_ack[i], ld_err[i], grant[i], busy[i], ram_en[i]}),
                32'(e_ctl[i]));
          if (e_ctl[i][0])
            check($sformatf("u%0d.ram{we,addr,wdata}", i),
                  32'({ram_we[i], ram_addr[i], ram_wdata[i]}),
                  32'({m_we[i], m_addr[i], m_wd[i]}));
          check($sformatf("u%0d.cpu_rdata", i), 32'(cpu_rdata[i]), 32'(e_rd_c[i]));
          check($sformatf("u%0d.ld_rdata", i), 32'(ld_rdata[i]), 32'(e_rd_l[i]));
          if (ram_en[i] === 1'b1) en_cnt[i]++;
        end
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the edge following the ack.
  task automatic do_req(input int i, input bit ld, input bit we, input logic [7:0] a,
                        input logic [15:0] d, input bit keep,
                        output int lat, output logic [15:0] rd, output bit er);
    bit got;
    got = 0; lat = 0; rd = '0; er = 0;
    if (ld) begin ld_req[i] = 1; ld_we[i] = we; ld_addr[i] = a; ld_wdata[i] = d; end
    else    begin cpu_req[i] = 1; cpu_we[i] = we; cpu_addr[i] = a; cpu_wdata[i] = d; end
    while (!got && lat < 64) begin
      @(negedge clk);
      if (ld ? ld_ack[i] : cpu_ack[i]) begin
        got = 1;
        rd  = ld ? ld_rdata[i] : cpu_rdata[i];
        er  = ld ? ld_err[i] : cpu_err[i];
      end else lat++;
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL u%0d.req_timeout ld=%0d: no ack within %0d cycles, ack required", i, ld, lat);
    end
    @(posedge clk); #1;
    if (!keep) begin
      if (ld) ld_req[i] = 0;
      else    cpu_req[i] = 0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, summary required");
    $fatal(1, "watchdog");
  end

  initial begin
    int lc, ll, e0, lk [3];
    logic [15:0] rc, rl;
    bit ec, el;
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      cpu_req[i] = 0; cpu_we[i] = 0; cpu_addr[i] = '0; cpu_wdata[i] = '0;
      ld_req[i] = 0; ld_we[i] = 0; ld_addr[i] = '0; ld_wdata[i] = '0; en_cnt[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst.u0.ctl", 32'({cpu_ack[0], cpu_err[0], ld_ack[0], ld_err[0], grant[0], busy[0], ram_en[0]}), 32'h0);
    check("rst.u1.ctl", 32'({cpu_ack[1], cpu_err[1], ld_ack[1], ld_err[1], grant[1], busy[1], ram_en[1]}), 32'h0);
    check("rst.u0.rdata", 32'({cpu_rdata[0], ld_rdata[0]}), 32'h0);
    check("rst.u1.rdata", 32'({cpu_rdata[1], ld_rdata[1]}), 32'h0);
    @(posedge clk); #1;

    // CPU write then read back
    e0 = en_cnt[0];
    do_req(0, 0, 1, 8'h10, 16'h1234, 0, lc, rc, ec);
    check("t1.wr_lat", 32'(lc), 32'd3);
    do_req(0, 0, 0, 8'h10, 16'h0, 0, lc, rc, ec);
    check("t1.rd_lat", 32'(lc), 32'd3);
    check("t1.rd_data", 32'(rc), 32'h1234);
    check("t1.ram_en_pulses", 32'(en_cnt[0] - e0), 32'd2);

    // address range boundary on the MEM_DEPTH=128 instance
    do_req(0, 0, 1, 8'h80, 16'hDEAD, 0, lc, rc, ec);
    check("bnd.err_lat", 32'(lc), 32'd1);
    check("bnd.err_flag", 32'(ec), 32'd1);
    do_req(0, 0, 0, 8'h7F, 16'h0, 0, lc, rc, ec);
    check("bnd.ok_flag", 32'(ec), 32'd0);
    check("bnd.ok_data", 32'(rc), 32'h2525);

    // loader read, then out-of-range loader read
    do_req(0, 1, 0, 8'h10, 16'h0, 0, ll, rl, el);
    check("ld.rd_data", 32'(rl), 32'h1234);
    e0 = en_cnt[0];
    do_req(0, 1, 0, 8'hFF, 16'h0, 0, ll, rl, el);
    check("ld.err_lat", 32'(ll), 32'd1);
    check("ld.err_flag", 32'(el), 32'd1);
    check("ld.err_rdata_kept", 32'(rl), 32'h1234);
    check("ld.err_no_ram_en", 32'(en_cnt[0] - e0), 32'd0);

    // simultaneous requests, round-robin
    for (int r = 0; r < 2; r++) begin
      fork
        do_req(0, 0, 1, 8'(8'h20 + r), 16'(16'h1000 + r), 0, lc, rc, ec);
        do_req(0, 1, 0, 8'h10, 16'h0, 0, ll, rl, el);
      join
      check($sformatf("rr%0d.cpu_lat", r), 32'(lc), 32'd3);
      check($sformatf("rr%0d.ld_lat", r), 32'(ll), 32'd7);
      check($sformatf("rr%0d.ld_data", r), 32'(rl), 32'h1234);
    end
    do_req(0, 0, 0, 8'h21, 16'h0, 0, lc, rc, ec);
    check("rr.cpu_wr_readback", 32'(rc), 32'h1001);

    // reset during WAIT of a CPU read drops it
    cpu_req[0] = 1; cpu_we[0] = 0; cpu_addr[0] = 8'h10;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    check("t5.busy_in_wait", 32'(busy[0]), 32'd1);
    @(posedge clk); #1;
    rst = 0; cpu_req[0] = 0;
    @(negedge clk);
    check("t5.busy_after_rst", 32'(busy[0]), 32'd0);
    check("t5.no_ack", 32'(cpu_ack[0]), 32'd0);
    check("t5.rdata_cleared", 32'(cpu_rdata[0]), 32'h0);
    @(posedge clk); #1;
    do_req(0, 0, 0, 8'h10, 16'h0, 0, lc, rc, ec);
    check("t5.reissue_lat", 32'(lc), 32'd3);
    check("t5.reissue_data", 32'(rc), 32'h1234);

    // request fields changed mid-transaction are ignored
    fork
      do_req(0, 0, 1, 8'h30, 16'h3333, 0, lc, rc, ec);
      begin @(posedge clk); #1; cpu_addr[0] = 8'h31; cpu_wdata[0] = 16'h9999; end
    join
    do_req(0, 0, 0, 8'h30, 16'h0, 0, lc, rc, ec);
    check("fld.latched_data", 32'(rc), 32'h3333);
    do_req(0, 0, 0, 8'h31, 16'h0, 0, lc, rc, ec);
    check("fld.other_untouched", 32'(rc), 32'h6B6B);

    // loader priority with ld_req held across three transactions
    fork
      begin
        for (int k = 0; k < 3; k++)
          do_req(1, 1, 1, 8'(8'h40 + k), 16'(16'hA000 + k), k < 2, lk[k], rl, el);
      end
      do_req(1, 0, 0, 8'h40, 16'h0, 0, lc, rc, ec);
    join
    check("pri.ld_lat0", 32'(lk[0]), 32'd5);
    check("pri.ld_lat2", 32'(lk[2]), 32'd5);
    check("pri.cpu_lat", 32'(lc), 32'd23);
    check("pri.cpu_data", 32'(rc), 32'hA000);

    // RAM_LAT=3: loader write, CPU read
    do_req(1, 1, 1, 8'h05, 16'hBEEF, 0, ll, rl, el);
    check("t6.ld_wr_lat", 32'(ll), 32'd5);
    do_req(1, 0, 0, 8'h05, 16'h0, 0, lc, rc, ec);
    check("t6.cpu_rd_lat", 32'(lc), 32'd5);
    check("t6.cpu_rd_data", 32'(rc), 32'hBEEF);

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
